// File: rtl/arbitro_rede_pkg.sv
// Shared definitions for the home uplink arbiter: state/owner encodings and the
// fixed-priority pick (TV > PC > Alexa). State values double as owner codes.
package arbitro_rede_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTv    = 2'd1,
        StPc    = 2'd2,
        StAlexa = 2'd3
    } state_e;

    localparam logic [1:0] OwnerNone  = 2'd0;
    localparam logic [1:0] OwnerTv    = 2'd1;
    localparam logic [1:0] OwnerPc    = 2'd2;
    localparam logic [1:0] OwnerAlexa = 2'd3;

    // req is packed as {alexa, pc, tv}
    function automatic state_e pick(input logic [2:0] req);
        if (req[0]) begin
            return StTv;
        end else if (req[1]) begin
            return StPc;
        end else if (req[2]) begin
            return StAlexa;
        end
        return StIdle;
    endfunction

    function automatic logic [2:0] own_mask(input state_e s);
        logic [2:0] m;
        m = 3'b000;
        unique case (s)
            StTv:    m = 3'b001;
            StPc:    m = 3'b010;
            StAlexa: m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/contador_quantum.sv
// Saturating cycle counter for grant tenure; at_limit flags QUANTUM-1.
module contador_quantum #(
    parameter int unsigned QUANTUM = 8,
    parameter int unsigned CW      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic at_limit
);

    localparam logic [CW-1:0] Limit = CW'(QUANTUM - 1);

    logic [CW-1:0] cnt_q;

    assign at_limit = (cnt_q == Limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !at_limit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_rede.sv
// Fixed-priority (TV > PC > Alexa) uplink arbiter with registered one-hot grants.
// Define ARBITRO_PREEMPT_EN to enable quantum-based preemption under contention.
module arbitro_rede
    import arbitro_rede_pkg::*;
#(
    parameter int unsigned QUANTUM = 8,
    parameter int unsigned CW      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_tv,
    input  logic       req_pc,
    input  logic       req_alexa,
    output logic       gnt_tv,
    output logic       gnt_pc,
    output logic       gnt_alexa,
    output logic [1:0] owner,
    output logic       busy
);

    logic [2:0] req;
    logic [2:0] others;
    logic [2:0] gnt_q;
    logic       at_limit;
    state_e     state_q, state_d;

    assign req = {req_alexa, req_pc, req_tv};

`ifdef ARBITRO_PREEMPT_EN
    logic cnt_clear;
    logic cnt_en;

    // Any state change restarts the tenure; a held grant keeps counting.
    assign cnt_clear = (state_d != state_q);
    assign cnt_en    = (state_q != StIdle);

    contador_quantum #(
        .QUANTUM (QUANTUM),
        .CW      (CW)
    ) u_contador (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .at_limit (at_limit)
    );
`else
    logic unused_cfg;

    assign at_limit   = 1'b0;
    assign unused_cfg = (QUANTUM > 0) && (CW > 0);
`endif

    always_comb begin
        others  = req & ~own_mask(state_q);
        state_d = state_q;
        if (state_q == StIdle) begin
            state_d = pick(req);
        end else if ((req & own_mask(state_q)) == 3'b000) begin
            state_d = pick(others);
        end else if (at_limit && (others != 3'b000)) begin
            state_d = pick(others);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            gnt_q   <= own_mask(state_d);
        end
    end

    assign gnt_tv    = gnt_q[0];
    assign gnt_pc    = gnt_q[1];
    assign gnt_alexa = gnt_q[2];
    assign owner     = state_q;
    assign busy      = (state_q != StIdle);

endmodule
